// File: rtl/clk_tick_monitor.sv
// Synchronises the divided slow clock into clk_in and emits one-cycle rise/fall ticks 3 cycles after a sampled change,
// measures each half-period and reports lock/timeout status; no backpressure, all outputs are free-running registers.
module clk_tick_monitor #(
    parameter int CNT_W          = 25,
    parameter int EXP_HALF       = 200001,
    parameter int TOL            = 16,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             locked,
    output logic             timeout_err,
    output logic [CNT_W-1:0] half_period
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W:0]   EXP_W    = (CNT_W + 1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   TMO_W    = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HCNT_MAX = '1;
    localparam logic [GW-1:0]    LOCK_N   = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    logic             s1_q, s2_q, s3_q;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             first_q, first_d;
    logic [GW-1:0]    good_q, good_d;
    state_t           state_q, state_d;

    logic             edge_rise, edge_fall, edge_any;
    logic [CNT_W:0]   meas, diff;
    logic             meas_good, tmo_hit;

    assign edge_rise = s2_q & ~s3_q;
    assign edge_fall = ~s2_q & s3_q;
    assign edge_any  = edge_rise | edge_fall;

    // Extra bit keeps hcnt+1 and the deviation free of wrap-around at saturation.
    assign meas      = {1'b0, hcnt_q} + (CNT_W + 1)'(1);
    assign diff      = (meas >= EXP_W) ? (meas - EXP_W) : (EXP_W - meas);
    assign meas_good = (diff <= TOL_W);
    assign tmo_hit   = !edge_any && (meas >= TMO_W);

    always_comb begin
        hcnt_d  = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + CNT_W'(1);
        hp_d    = hp_q;
        first_d = first_q;
        good_d  = good_q;
        state_d = state_q;

        if (edge_any) begin
            hcnt_d = '0;
            if (first_q) begin
                // The first edge after reset or timeout only opens a measurement window.
                first_d = 1'b0;
                state_d = ST_ACQUIRE;
            end else begin
                hp_d = meas[CNT_W] ? HCNT_MAX : meas[CNT_W-1:0];
                unique case (state_q)
                    ST_ACQUIRE: begin
                        if (meas_good) begin
                            if (good_q + GW'(1) == LOCK_N) begin
                                state_d = ST_LOCKED;
                                good_d  = '0;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!meas_good) begin
                            state_d = ST_ACQUIRE;
                            good_d  = '0;
                        end
                    end
                    default: begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                    end
                endcase
            end
        end else if (tmo_hit) begin
            state_d = ST_LOST;
            good_d  = '0;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            hcnt_q  <= '0;
            hp_q    <= '0;
            first_q <= 1'b1;
            good_q  <= '0;
            state_q <= ST_ACQUIRE;
        end else begin
            s1_q    <= slow_clk;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            rise_q  <= edge_rise;
            fall_q  <= edge_fall;
            hcnt_q  <= hcnt_d;
            hp_q    <= hp_d;
            first_q <= first_d;
            good_q  <= good_d;
            state_q <= state_d;
        end
    end

    assign rise_tick   = rise_q;
    assign fall_tick   = fall_q;
    assign locked      = (state_q == ST_LOCKED);
    assign timeout_err = (state_q == ST_LOST);
    assign half_period = hp_q;

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Bench for clk_tick_monitor: directed scenarios plus randomized half-periods and resets,
// checked every cycle against a timestamp-based model of the monitor.
module tb_clk_tick_monitor;

    localparam int CNT_W = 8;
    localparam int EXP   = 10;
    localparam int TOL   = 1;
    localparam int LCK   = 4;
    localparam int TMO   = 30;

    logic             clk_in   = 1'b0;
    logic             rst      = 1'b1;
    logic             slow_clk = 1'b0;
    logic             rise_tick, fall_tick, locked, timeout_err;
    logic [CNT_W-1:0] half_period;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    clk_tick_monitor #(
        .CNT_W(CNT_W), .EXP_HALF(EXP), .TOL(TOL), .LOCK_COUNT(LCK), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk),
        .rise_tick(rise_tick), .fall_tick(fall_tick), .locked(locked),
        .timeout_err(timeout_err), .half_period(half_period)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    // Model: edges are sample-history changes; measurements are timestamp differences.
    bit h1, h2, h3;
    int m_t = 0, m_tlast = 0;
    bit m_first = 1'b1;
    int m_state = 0;   // 0 acquiring, 1 locked, 2 lost
    int m_good = 0, m_hp = 0;
    bit m_rise = 1'b0, m_fall = 1'b0;

    initial begin : model
        int  meas;
        bit  ev, good;
        forever begin
            @(posedge clk_in or posedge rst);
            if (rst) begin
                h1 = 0; h2 = 0; h3 = 0;
                m_tlast = m_t; m_first = 1; m_state = 0; m_good = 0; m_hp = 0;
                m_rise = 0; m_fall = 0;
            end else begin
                m_t++;
                ev     = (h2 != h3);
                m_rise = ev && h2;
                m_fall = ev && !h2;
                meas   = m_t - m_tlast;
                if (meas > 256) meas = 256;
                if (ev) begin
                    m_tlast = m_t;
                    if (m_first) begin
                        m_first = 0;
                        m_state = 0;
                    end else begin
                        m_hp = (meas > 255) ? 255 : meas;
                        good = (meas >= EXP - TOL) && (meas <= EXP + TOL);
                        if (m_state == 0) begin
                            if (good) begin
                                m_good++;
                                if (m_good == LCK) begin m_state = 1; m_good = 0; end
                            end else m_good = 0;
                        end else if (!good) begin
                            m_state = 0; m_good = 0;
                        end
                    end
                end else if (meas >= TMO) begin
                    m_state = 2; m_good = 0; m_first = 1;
                end
                h3 = h2; h2 = h1; h1 = slow_clk;
            end
        end
    end

    initial begin : compare
        logic [11:0] got, exp;
        forever begin
            @(negedge clk_in);
            got = {rise_tick, fall_tick, locked, timeout_err, half_period};
            exp = {m_rise, m_fall, m_state == 1, m_state == 2, 8'(m_hp)};
            chk("cycle {rise,fall,locked,timeout,half_period}", 32'(got), 32'(exp));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "bench stopped by watchdog");
    end

    task automatic hp(input int n, output int tick_at);
        bit pol;
        slow_clk = ~slow_clk;
        pol      = slow_clk;
        tick_at  = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_in);
            if (tick_at == 0 && (pol ? rise_tick : fall_tick)) tick_at = i;
        end
    endtask

    task automatic hp_n(input int n);
        int ta;
        hp(n, ta);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({rise_tick, fall_tick, locked, timeout_err, half_period}), 32'd0);
    endtask

    initial begin : stim
        int ta, r;
        // Reset held while slow_clk toggles.
        repeat (3) @(negedge clk_in);
        slow_clk = 1'b1;
        repeat (3) @(negedge clk_in);
        chk_all_zero("outputs_in_reset_high");
        slow_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_all_zero("outputs_in_reset_low");
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            chk("no_tick_after_release", 32'(rise_tick | fall_tick), 32'd0);
        end

        // Nominal 10-cycle half-periods.
        hp(10, ta); chk("rise_tick_latency", 32'(ta), 32'd3);
        hp(10, ta); chk("fall_tick_latency", 32'(ta), 32'd3);
        hp_n(10);
        hp_n(10);
        chk("unlocked_after_4_ticks", 32'(locked), 32'd0);
        hp_n(10);
        chk("locked_after_5_ticks", 32'(locked), 32'd1);
        chk("half_period_10", 32'(half_period), 32'd10);

        // Jitter within tolerance, then one bad half-period.
        hp_n(9); hp_n(11); hp_n(9); hp_n(13);
        chk("locked_through_jitter", 32'(locked), 32'd1);
        chk("half_period_9", 32'(half_period), 32'd9);
        hp_n(10);
        chk("unlock_on_13", 32'(locked), 32'd0);
        chk("half_period_13", 32'(half_period), 32'd13);
        hp_n(10); hp_n(10); hp_n(10);
        chk("still_acquiring", 32'(locked), 32'd0);

        // Relock, then stop the slow clock.
        slow_clk = ~slow_clk;
        repeat (3) @(negedge clk_in);
        chk("relocked", 32'(locked), 32'd1);
        repeat (29) @(negedge clk_in);
        chk("no_timeout_at_29", 32'(timeout_err), 32'd0);
        chk("locked_at_29", 32'(locked), 32'd1);
        @(negedge clk_in);
        chk("timeout_at_30", 32'(timeout_err), 32'd1);
        chk("unlocked_at_timeout", 32'(locked), 32'd0);

        // Resume toggling.
        slow_clk = ~slow_clk;
        repeat (2) @(negedge clk_in);
        chk("timeout_held_before_tick", 32'(timeout_err), 32'd1);
        @(negedge clk_in);
        chk("timeout_cleared_at_tick", 32'(timeout_err), 32'd0);
        repeat (7) @(negedge clk_in);
        hp_n(10); hp_n(10); hp_n(10);
        chk("resume_not_yet_locked", 32'(locked), 32'd0);
        hp_n(10);
        chk("resume_locked_5th_tick", 32'(locked), 32'd1);

        // Edge coincides with the timeout cycle.
        hp_n(30);
        hp_n(10);
        chk("edge_beats_timeout", 32'(timeout_err), 32'd0);
        chk("half_period_30", 32'(half_period), 32'd30);

        // Async reset with a fall tick in flight.
        hp_n(10); hp_n(10); hp_n(10); hp_n(10);
        if (slow_clk == 1'b0) hp_n(10);
        chk("locked_before_async_rst", 32'(locked), 32'd1);
        slow_clk = 1'b0;
        @(posedge clk_in);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset_immediate");
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            chk("no_pending_tick_after_rst", 32'(rise_tick | fall_tick), 32'd0);
        end

        // Randomized half-periods and resets.
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                @(posedge clk_in);
                #($urandom_range(1, 4)) rst = 1'b1;
                #1 chk_all_zero("random_async_reset");
                repeat (2) @(negedge clk_in);
                rst = 1'b0;
            end else if (r <= 3) begin
                hp_n($urandom_range(1, 45));
            end else if (r <= 5) begin
                hp_n($urandom_range(28, 32));
            end else begin
                hp_n($urandom_range(9, 11));
            end
        end
        repeat (40) @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_tick_monitor.md
Name: clk_tick_monitor

Overview:
- Receiving end of the divided slow clock. Brings the slow clock into the fast clk_in domain and issues single-cycle rise/fall enable ticks for downstream elevator logic.
- Measures every half-period in clk_in cycles and reports lock status.
- Flags a timeout when the slow clock stops toggling.
- Sits between the clock divider and the FSM/timer blocks, which run on clk_in gated by ticks rather than on the divided clock.

Parameters:
- CNT_W, 25, width of the half-period counter and the half_period output.
- EXP_HALF, 200001, expected half-period in clk_in cycles.
- TOL, 16, allowed absolute deviation from EXP_HALF for a measurement to count as good.
- LOCK_COUNT, 4, number of consecutive good measurements required to declare lock.
- TIMEOUT_CYCLES, 400000, number of cycles without an edge that raises timeout_err.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- slow_clk  input  1  divided clock. It is asynchronous to the monitor's sampling and is treated as such.
- rise_tick  output  1  one-cycle pulse per detected rising edge of slow_clk.
- fall_tick  output  1  one-cycle pulse per detected falling edge of slow_clk.
- locked  output  1  high while the measured half-periods are within tolerance.
- timeout_err  output  1  high after TIMEOUT_CYCLES cycles with no edge.
- half_period  output  CNT_W  most recent measured half-period, in clk_in cycles.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0.
  - Sync flops, counters and the first_edge flag are cleared; first_edge=1.
  - FSM goes to ACQUIRE.
  - Asserting reset mid-operation has immediate effect regardless of the current state.
- Synchronizer and edge detection:
  - Chain s1 -> s2 -> s3, all reset to 0.
  - Rising edge = s2 & ~s3; falling edge = ~s2 & s3.
  - Ticks are registered. A slow_clk transition sampled at clk_in edge k produces a tick high during the cycle after edge k+2, for exactly one cycle.
  - Ticks are issued in every FSM state.
- Half-period counter hcnt:
  - Increments every cycle and saturates at 2^CNT_W-1.
  - On a detected edge (either polarity), the measurement equals hcnt+1 and hcnt is reloaded to 0. Consequently, edges N cycles apart measure N.
  - When first_edge=1, the measurement is discarded: half_period and the FSM are unchanged, and first_edge clears.
  - Otherwise half_period is updated with the measurement, registered at the same edge as the tick.
- Good measurement: |meas - EXP_HALF| <= TOL. Compute the difference at CNT_W+1 bits, with no wrap-around.
- FSM states: ACQUIRE, LOCKED, LOST. good_cnt has width ceil(log2(LOCK_COUNT+1)).
- ACQUIRE:
  - Good measurement: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED, set locked=1 and clear good_cnt.
  - Bad measurement: good_cnt=0.
- LOCKED:
  - Good measurement: stay in LOCKED.
  - Bad measurement: go to ACQUIRE, locked=0, good_cnt=0. first_edge is not set, so this bad edge opens the next measurement.
- Timeout (any state):
  - If hcnt+1 reaches TIMEOUT_CYCLES with no edge in that cycle, go to LOST: timeout_err=1, locked=0, good_cnt=0, first_edge=1.
- LOST:
  - timeout_err stays high.
  - The next detected edge goes to ACQUIRE and clears timeout_err. That edge is discarded as first_edge.
- Simultaneous edge and timeout in the same cycle: the edge wins and no timeout is raised.
- locked and timeout_err are never both 1.

Test Plan (bench parameters: EXP_HALF=10, TOL=1, LOCK_COUNT=4, TIMEOUT_CYCLES=30, CNT_W=8):
1. Hold rst=1, then toggle slow_clk -> all outputs stay 0. Release rst -> FSM is in ACQUIRE and no ticks occur until slow_clk changes.
2. Toggle slow_clk every 10 cycles, starting low -> rise_tick and fall_tick alternate, each 1 cycle wide, 3 cycles after the input change; half_period=10. locked=1 in the cycle after the 5th tick (1 discarded + 4 good).
3. While locked, half-periods of 9, 11, 9 -> locked stays 1. Then one half-period of 13 -> locked=0, half_period=13. Next 4 half-periods of 10 -> locked=1 again.
4. While locked, hold slow_clk constant -> timeout_err=1 and locked=0 exactly 30 cycles after the last tick. Resume 10-cycle toggling -> timeout_err=0 at the first tick; locked=1 after the 5th tick.
5. Edge arriving in the same cycle the timeout would fire (half-period 30) -> timeout_err stays 0 and half_period=30.
6. Assert rst asynchronously, mid-cycle, while locked with a tick pending -> locked, ticks and half_period go to 0 immediately with no clock edge, and no tick is emitted after release.
